program_loader: RTL and testbench

Boot-time loader that fills the instruction memory read by the CPU's fetch path. It accepts a little-endian byte stream over a valid/ready handshake, assembles 32-bit instruction words, and writes them to consecutive word-aligned byte addresses starting at 0. It holds the CPU in reset until the halt word (32'hFFFFFFFF) has been written, then releases it.

---
 rtl/loader_pkg.sv | 18 +
 rtl/word_assembler.sv | 43 ++++
 rtl/program_loader.sv | 122 ++++++++++++
 tb/tb_program_loader.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// loader_pkg: types and constants shared by the program loader and the CPU.
//   loader_state_t : loader FSM states
//   HALT_WORD      : instruction word that terminates an image (also decoded by is_halt)
//   WORD_BYTES     : bytes per instruction word
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RECV,
    WRITE,
    DONE,
    ERROR
  } loader_state_t;

  localparam logic [31:0] HALT_WORD  = 32'hFFFF_FFFF;
  localparam int unsigned WORD_BYTES = 4;

endpackage

// File: rtl/word_assembler.sv
// word_assembler: packs a little-endian byte stream into 32-bit words.
//   clock, reset : system clock, synchronous active-high reset
//   clear        : restart at byte 0 (drops any partial word)
//   byte_valid   : byte_in is taken this cycle
//   byte_in      : incoming byte
//   word_out     : current word with byte_in already inserted at the active lane
//   word_ready   : this cycle's byte completes a word (word_out is the full word)
module word_assembler
  import loader_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic [31:0] word_out,
  output logic        word_ready
);

  logic [1:0]  byte_idx;
  logic [31:0] word_q;

  // The completed word is offered combinationally on the same cycle the last
  // byte arrives, so the caller can register it without an extra stage.
  always_comb begin
    word_out = word_q;
    if (byte_valid) begin
      word_out[{byte_idx, 3'b000} +: 8] = byte_in;
    end
    word_ready = byte_valid && (byte_idx == 2'(WORD_BYTES - 1));
  end

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      byte_idx <= '0;
      word_q   <= '0;
    end else if (byte_valid) begin
      byte_idx <= byte_idx + 2'd1;
      word_q   <= word_out;
    end
  end

endmodule

// File: rtl/program_loader.sv
// program_loader: boot-time loader filling instruction memory from a byte stream.
//   clock, reset          : system clock, synchronous active-high reset
//   start                 : begin a load session (honoured in IDLE, DONE, ERROR)
//   in_valid/in_data      : byte stream, little-endian words
//   in_ready              : byte stream ready (high only while receiving)
//   imem_we/addr/wdata    : one-cycle instruction memory write per word
//   cpu_reset             : holds the CPU in reset until a halt word is written
//   busy / done / error   : RECV or WRITE / halt word loaded / no halt within DEPTH words
//   word_count            : words written in the current session
module program_loader
  import loader_pkg::*;
#(
  parameter int DEPTH      = 64,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       in_valid,
  input  logic [7:0]                 in_data,
  output logic                       in_ready,
  output logic                       imem_we,
  output logic [ADDR_WIDTH-1:0]      imem_addr,
  output logic [31:0]                imem_wdata,
  output logic                       cpu_reset,
  output logic                       busy,
  output logic                       done,
  output logic                       error,
  output logic [$clog2(DEPTH+1)-1:0] word_count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_CW = CW'(DEPTH);

  loader_state_t         state;
  loader_state_t         state_next;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [CW-1:0]         word_count_inc;
  logic                  start_ok;
  logic                  byte_valid;
  logic                  asm_clear;
  logic [31:0]           asm_word;
  logic                  asm_ready;

  assign start_ok       = start && (state == IDLE || state == DONE || state == ERROR);
  // in_ready is registered and only ever high in RECV, so it alone qualifies a byte.
  assign byte_valid     = in_valid && in_ready;
  assign asm_clear      = start_ok || (state == WRITE);
  assign word_count_inc = word_count + CW'(1);

  word_assembler u_word_assembler (
    .clock      (clock),
    .reset      (reset),
    .clear      (asm_clear),
    .byte_valid (byte_valid),
    .byte_in    (in_data),
    .word_out   (asm_word),
    .word_ready (asm_ready)
  );

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE, ERROR: if (start) state_next = RECV;
      RECV:              if (asm_ready) state_next = WRITE;
      WRITE: begin
        // Halt check precedes the capacity check: a halt in the last slot is DONE.
        if (imem_wdata == HALT_WORD)          state_next = DONE;
        else if (word_count_inc == DEPTH_CW)  state_next = ERROR;
        else                                  state_next = RECV;
      end
      default: state_next = IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up with
  // the state they describe rather than lagging it by a cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      in_ready   <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_reset  <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      word_count <= '0;
      addr_q     <= '0;
    end else begin
      state     <= state_next;
      in_ready  <= (state_next == RECV);
      imem_we   <= (state_next == WRITE);
      busy      <= (state_next == RECV) || (state_next == WRITE);
      done      <= (state_next == DONE);
      error     <= (state_next == ERROR);
      cpu_reset <= (state_next != DONE);

      case (state)
        IDLE, DONE, ERROR: begin
          if (start) begin
            word_count <= '0;
            addr_q     <= '0;
          end
        end
        RECV: begin
          if (asm_ready) begin
            imem_addr  <= addr_q;
            imem_wdata <= asm_word;
          end
        end
        WRITE: begin
          word_count <= word_count_inc;
          addr_q     <= addr_q + ADDR_WIDTH'(WORD_BYTES);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;

  always #5 clock = ~clock;

  // dut_a: DEPTH=64, dut_b: DEPTH=4; both see identical stimulus.
  logic        a_ready, a_we, a_cpu, a_busy, a_done, a_err;
  logic [31:0] a_addr, a_wdata;
  logic [6:0]  a_wc;
  logic        b_ready, b_we, b_cpu, b_busy, b_done, b_err;
  logic [31:0] b_addr, b_wdata;
  logic [2:0]  b_wc;

  program_loader #(.DEPTH(64), .ADDR_WIDTH(32)) dut_a (
    .clock(clock), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(a_ready), .imem_we(a_we), .imem_addr(a_addr), .imem_wdata(a_wdata),
    .cpu_reset(a_cpu), .busy(a_busy), .done(a_done), .error(a_err), .word_count(a_wc)
  );

  program_loader #(.DEPTH(4), .ADDR_WIDTH(32)) dut_b (
    .clock(clock), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(b_ready), .imem_we(b_we), .imem_addr(b_addr), .imem_wdata(b_wdata),
    .cpu_reset(b_cpu), .busy(b_busy), .done(b_done), .error(b_err), .word_count(b_wc)
  );

  int total = 0;
  int bad   = 0;
  logic [63:0] qa[$];
  logic [63:0] qb[$];
  logic [63:0] ea, eb;
  logic [31:0] exp_addr = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard consumers: every write strobe must match the oldest expected write.
  always @(negedge clock) begin
    if (a_we) begin
      if (qa.size() == 0) chk("a_we_unexpected", 64'd1, 64'd0);
      else begin
        ea = qa.pop_front();
        chk("a_addr", {32'd0, a_addr}, {32'd0, ea[63:32]});
        chk("a_data", {32'd0, a_wdata}, {32'd0, ea[31:0]});
      end
    end
  end

  always @(negedge clock) begin
    if (b_we) begin
      if (qb.size() == 0) chk("b_we_unexpected", 64'd1, 64'd0);
      else begin
        eb = qb.pop_front();
        chk("b_addr", {32'd0, b_addr}, {32'd0, eb[63:32]});
        chk("b_data", {32'd0, b_wdata}, {32'd0, eb[31:0]});
      end
    end
  end

  // Called at a negedge; returns at the negedge after the byte was accepted.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!(a_ready && b_ready) && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (n >= 50) chk("ready_timeout", 64'd1, 64'd0);
    @(negedge clock);
    in_valid = 1'b0;
    repeat (gap) @(negedge clock);
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int unsigned k = 0; k < 4; k++) begin
      if (k == 3) begin
        qa.push_back({exp_addr, w});
        qb.push_back({exp_addr, w});
        exp_addr = exp_addr + 32'd4;
      end
      send_byte(w[8*k +: 8], gap);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    exp_addr = '0;
    chk("start_ready", {63'd0, a_ready}, 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clock);
    chk("rst_ready", {63'd0, a_ready}, 64'd0);
    chk("rst_we",    {63'd0, a_we},    64'd0);
    chk("rst_addr",  {32'd0, a_addr},  64'd0);
    chk("rst_wdata", {32'd0, a_wdata}, 64'd0);
    chk("rst_cpu",   {63'd0, a_cpu},   64'd1);
    chk("rst_busy",  {63'd0, a_busy},  64'd0);
    chk("rst_done",  {63'd0, a_done},  64'd0);
    chk("rst_err",   {63'd0, a_err},   64'd0);
    chk("rst_wc",    {57'd0, a_wc},    64'd0);
    chk("rst_b_cpu", {63'd0, b_cpu},   64'd1);
    reset = 1'b0;
    @(negedge clock);
    chk("idle_cpu",   {63'd0, a_cpu},   64'd1);
    chk("idle_ready", {63'd0, a_ready}, 64'd0);

    // Basic image: addi x1,x0,5 then halt.
    do_start();
    chk("recv_busy", {63'd0, a_busy}, 64'd1);
    send_word(32'h0050_0093, 0);
    chk("write_ready", {63'd0, a_ready}, 64'd0);
    chk("write_busy",  {63'd0, a_busy},  64'd1);
    @(negedge clock);
    chk("post_write_ready", {63'd0, a_ready}, 64'd1);
    send_word(32'hFFFF_FFFF, 0);
    chk("halt_write_cpu", {63'd0, a_cpu}, 64'd1);
    @(negedge clock);
    chk("t1_done", {63'd0, a_done}, 64'd1);
    chk("t1_cpu",  {63'd0, a_cpu},  64'd0);
    chk("t1_wc",   {57'd0, a_wc},   64'd2);
    chk("t1_busy", {63'd0, a_busy}, 64'd0);
    chk("t1_b_done", {63'd0, b_done}, 64'd1);

    // Same image with in_valid toggling every other cycle.
    do_reset();
    do_start();
    send_word(32'h0050_0093, 1);
    send_word(32'hFFFF_FFFF, 1);
    chk("t2_done", {63'd0, a_done}, 64'd1);
    chk("t2_wc",   {57'd0, a_wc},   64'd2);

    // Four non-halt words: DEPTH=4 errors, DEPTH=64 keeps receiving.
    do_reset();
    do_start();
    send_word(32'h1122_3344, 0);
    send_word(32'h5566_7788, 0);
    send_word(32'h99AA_BBCC, 0);
    send_word(32'h0000_0013, 0);
    @(negedge clock);
    chk("t3_b_err",  {63'd0, b_err},  64'd1);
    chk("t3_b_cpu",  {63'd0, b_cpu},  64'd1);
    chk("t3_b_done", {63'd0, b_done}, 64'd0);
    chk("t3_b_wc",   {61'd0, b_wc},   64'd4);
    chk("t3_a_ready", {63'd0, a_ready}, 64'd1);
    chk("t3_a_err",  {63'd0, a_err},  64'd0);
    repeat (5) @(negedge clock);
    chk("t3_b_err_hold", {63'd0, b_err}, 64'd1);
    chk("t3_b_cpu_hold", {63'd0, b_cpu}, 64'd1);
    chk("t3_a_wc",       {57'd0, a_wc},  64'd4);

    // Halt as the DEPTH-th word: DONE, not ERROR.
    do_reset();
    do_start();
    send_word(32'hA5A5_0001, 0);
    send_word(32'hA5A5_0002, 0);
    send_word(32'hA5A5_0003, 0);
    send_word(32'hFFFF_FFFF, 0);
    @(negedge clock);
    chk("t4_b_done", {63'd0, b_done}, 64'd1);
    chk("t4_b_err",  {63'd0, b_err},  64'd0);
    chk("t4_b_cpu",  {63'd0, b_cpu},  64'd0);
    chk("t4_a_done", {63'd0, a_done}, 64'd1);

    // Reset after two bytes of word 1, then a fresh load.
    do_reset();
    do_start();
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("t5_busy",  {63'd0, a_busy},  64'd0);
    chk("t5_cpu",   {63'd0, a_cpu},   64'd1);
    chk("t5_wc",    {57'd0, a_wc},    64'd0);
    chk("t5_we",    {63'd0, a_we},    64'd0);
    chk("t5_ready", {63'd0, a_ready}, 64'd0);
    @(negedge clock);
    chk("t5_we2",   {63'd0, a_we},    64'd0);
    do_start();
    send_word(32'h1234_5678, 0);
    send_word(32'hFFFF_FFFF, 0);
    @(negedge clock);
    chk("t5_done", {63'd0, a_done}, 64'd1);

    // Reload from DONE.
    do_start();
    chk("t6_cpu",   {63'd0, a_cpu},  64'd1);
    chk("t6_b_cpu", {63'd0, b_cpu},  64'd1);
    chk("t6_done",  {63'd0, a_done}, 64'd0);
    send_word(32'hCAFE_F00D, 0);
    send_word(32'hFFFF_FFFF, 0);
    @(negedge clock);
    chk("t6_done2", {63'd0, a_done}, 64'd1);
    chk("t6_cpu2",  {63'd0, a_cpu},  64'd0);
    chk("t6_wc",    {57'd0, a_wc},   64'd2);

    @(negedge clock);
    chk("qa_drained", 64'(qa.size()), 64'd0);
    chk("qb_drained", 64'(qb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
